// File: rtl/read_guard.sv
// read_guard: AXI read-path watchdog. Tracks accepted AR bursts, budgets each one and retires them on R beats in per-ID order.
// Optional protocol-fault detection on unexpected R beats is enabled by defining READ_GUARD_UNEXP_RSP_EN.
package read_guard_pkg;
    typedef logic [3:0] id_t;

    typedef struct packed {
        logic       ar_valid;
        id_t        ar_id;
        logic [7:0] ar_len;
        logic       r_ready;
    } req_t;

    typedef struct packed {
        logic ar_ready;
        logic r_valid;
        id_t  r_id;
        logic r_last;
    } rsp_t;
endpackage

module read_guard #(
    parameter int unsigned MaxRdTxns    = 8,
    parameter int unsigned CntWidth     = 10,
    parameter int unsigned PrescalerDiv = 1,
    parameter type         id_t         = read_guard_pkg::id_t,
    parameter type         req_t        = read_guard_pkg::req_t,
    parameter type         rsp_t        = read_guard_pkg::rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rd_en_i,
    input  req_t                mst_req_i,
    input  rsp_t                slv_rsp_i,
    input  logic [CntWidth-1:0] budget_read_i,
    input  logic [3:0]          budget_beat_i,
    input  logic                reset_clear_i,
    output logic                reset_req_o,
    output logic                irq_o,
    output logic                txn_full_o,
    output logic                ovf_o,
    output id_t                 timeout_id_o
);
    localparam int unsigned     PredW   = $clog2(MaxRdTxns + 1);
    localparam int unsigned     IdxW    = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    localparam int unsigned     PscW    = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam int unsigned     SumW    = CntWidth + 13;
    localparam logic [PscW-1:0] PscLast = PscW'(PrescalerDiv - 1);
    localparam logic [SumW-1:0] CntMax  = SumW'((64'd1 << CntWidth) - 1);

    // beats_left has a ninth bit so that len=255 (256 beats) still fits.
    typedef struct packed {
        logic                valid;
        id_t                 id;
        logic [8:0]          beats_left;
        logic [PredW-1:0]    pred_cnt;
        logic [CntWidth-1:0] cnt;
    } entry_t;

    entry_t        tbl_q [MaxRdTxns];
    entry_t        tbl_d [MaxRdTxns];
    logic [PscW-1:0] presc_q, presc_d;
    logic          reset_req_q, reset_req_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;
    id_t           tid_q, tid_d;

    logic            tick, count_en, ar_hs, r_beat, full, fault;
    logic            to_hit, head_hit;
    id_t             to_id;
    logic [IdxW-1:0] free_idx, head_idx;
    logic [PredW-1:0] same_cnt;
    logic [SumW-1:0] budget_sum;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        tbl_d       = tbl_q;
        reset_req_d = reset_req_q;
        ovf_d       = ovf_q;
        tid_d       = tid_q;
        irq_d       = 1'b0;
        tick        = (presc_q == PscLast);
        presc_d     = tick ? '0 : presc_q + PscW'(1);
        count_en    = tick & rd_en_i & ~reset_req_q;
        ar_hs       = mst_req_i.ar_valid & slv_rsp_i.ar_ready & rd_en_i & ~reset_req_q;
        r_beat      = slv_rsp_i.r_valid & mst_req_i.r_ready;
        full        = 1'b1;
        free_idx    = '0;
        to_hit      = 1'b0;
        to_id       = '0;
        head_hit    = 1'b0;
        head_idx    = '0;
        same_cnt    = '0;
        budget_sum  = '0;

        // All lookups see the table as it stood at the start of the cycle.
        for (int unsigned i = 0; i < MaxRdTxns; i++) begin
            if (!tbl_q[i].valid && full) begin
                full     = 1'b0;
                free_idx = IdxW'(i);
            end
            if (tbl_q[i].valid && tbl_q[i].cnt == '0 && !to_hit) begin
                to_hit = 1'b1;
                to_id  = tbl_q[i].id;
            end
            if (tbl_q[i].valid && tbl_q[i].id == slv_rsp_i.r_id && tbl_q[i].pred_cnt == '0) begin
                head_hit = 1'b1;
                head_idx = IdxW'(i);
            end
        end
        to_hit = to_hit & count_en;

`ifdef READ_GUARD_UNEXP_RSP_EN
        fault = r_beat & (~head_hit | (slv_rsp_i.r_last & (tbl_q[head_idx].beats_left != 9'd1)));
`else
        fault = 1'b0;
`endif

        if (count_en) begin
            for (int unsigned i = 0; i < MaxRdTxns; i++) begin
                if (tbl_q[i].valid && tbl_q[i].cnt != '0) begin
                    tbl_d[i].cnt = tbl_q[i].cnt - CntWidth'(1);
                end
            end
        end

        if (r_beat && head_hit) begin
            tbl_d[head_idx].beats_left = tbl_q[head_idx].beats_left - 9'd1;
            if (slv_rsp_i.r_last || tbl_q[head_idx].beats_left == 9'd1) begin
                tbl_d[head_idx].valid = 1'b0;
                for (int unsigned i = 0; i < MaxRdTxns; i++) begin
                    if (IdxW'(i) != head_idx && tbl_q[i].valid && tbl_q[i].id == slv_rsp_i.r_id) begin
                        tbl_d[i].pred_cnt = tbl_q[i].pred_cnt - PredW'(1);
                    end
                end
            end
        end

        // Enqueue counts predecessors after retirement; the free index comes from the old table.
        if (ar_hs) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < MaxRdTxns; i++) begin
                    if (tbl_d[i].valid && tbl_d[i].id == mst_req_i.ar_id) begin
                        same_cnt = same_cnt + PredW'(1);
                    end
                end
                budget_sum = SumW'(budget_read_i)
                           + (SumW'(mst_req_i.ar_len) + SumW'(1)) * SumW'(budget_beat_i);
                tbl_d[free_idx].valid      = 1'b1;
                tbl_d[free_idx].id         = mst_req_i.ar_id;
                tbl_d[free_idx].beats_left = {1'b0, mst_req_i.ar_len} + 9'd1;
                tbl_d[free_idx].pred_cnt   = same_cnt;
                tbl_d[free_idx].cnt        = (budget_sum > CntMax) ? '1 : budget_sum[CntWidth-1:0];
            end
        end

        if (!reset_req_q && (to_hit || fault)) begin
            reset_req_d = 1'b1;
            irq_d       = 1'b1;
            tid_d       = to_hit ? to_id : slv_rsp_i.r_id;
        end

        if (reset_clear_i) begin
            for (int unsigned i = 0; i < MaxRdTxns; i++) begin
                tbl_d[i].valid = 1'b0;
            end
            reset_req_d = 1'b0;
            irq_d       = 1'b0;
            ovf_d       = 1'b0;
            tid_d       = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: whole entries are reset, not just valid bits, so no X can reach a compare.
            for (int unsigned i = 0; i < MaxRdTxns; i++) begin
                tbl_q[i] <= '0;
            end
            presc_q     <= '0;
            reset_req_q <= 1'b0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
            tid_q       <= '0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values.
            tbl_q       <= tbl_d;
            presc_q     <= presc_d;
            reset_req_q <= reset_req_d;
            irq_q       <= irq_d;
            ovf_q       <= ovf_d;
            tid_q       <= tid_d;
        end
    end

    assign reset_req_o  = reset_req_q;
    assign irq_o        = irq_q;
    assign txn_full_o   = full;
    assign ovf_o        = ovf_q;
    assign timeout_id_o = tid_q;
endmodule
